// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer.
//   - op_e    : operation encodings carried on the op port
//   - state_e : sequencer FSM states
//   - skips_shift() : true when an accepted request goes straight to FINISH
package shift_sequencer_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    FINISH = 2'b10
  } state_e;

  // A zero distance or the reserved op needs no shift cycles at all.
  function automatic logic skips_shift(input op_e op, input logic [CNT_W-1:0] amt);
    return (amt == '0) || (op == OP_RSVD);
  endfunction

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-step combinational shifter: moves A by one bit position.
// Ports:
//   A  : operand
//   LA : arithmetic fill for right shifts (replicate the sign bit)
//   LR : direction, 0 = left, 1 = right
//   Y  : shifted operand
//   C  : the bit that falls off the end
module shifter
  import shift_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic              LA,
  input  logic              LR,
  output logic [DATA_W-1:0] Y,
  output logic              C
);

  assign Y = LR ? {LA & A[DATA_W-1], A[DATA_W-1:1]} : {A[DATA_W-2:0], 1'b0};
  assign C = LR ? A[0] : A[DATA_W-1];

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: one 1-bit shift per cycle, amt cycles total.
// Ports:
//   clk, reset       : rising-edge clock, asynchronous active-high reset
//   start            : request, honoured only in IDLE
//   op, amt, din     : operation, distance (0..7) and operand, captured with start
//   busy             : high while shifting
//   done             : one-cycle completion pulse
//   dout, carry, err : result, last bit shifted out, reserved-op flag
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [CNT_W-1:0]  amt,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dout,
  output logic              carry,
  output logic              err
);

  state_e            state, state_next;
  op_e               op_q;
  op_e               op_in;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] work_q;
  logic [DATA_W-1:0] shift_y;
  logic              shift_c;

  assign op_in = op_e'(op);

  shifter u_shifter (
    .A  (work_q),
    .LA (op_q == OP_SRA),
    .LR (op_q != OP_SLL),
    .Y  (shift_y),
    .C  (shift_c)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: next_state gets its default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = skips_shift(op_in, amt) ? FINISH : SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. dout is loaded on the edge that enters FINISH so the result is
  // already valid during the done cycle; the reserved op leaves it untouched.
  // NOTE: every datapath register is reset, because a mid-operation reset must
  // leave no trace of the aborted operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_q <= '0;
      op_q   <= OP_SLL;
      cnt_q  <= '0;
      dout   <= '0;
      carry  <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work_q <= din;
            op_q   <= op_in;
            cnt_q  <= amt;
            carry  <= 1'b0;
            err    <= (op_in == OP_RSVD);
            if (amt == '0 && op_in != OP_RSVD) dout <= din;
          end
        end
        SHIFT: begin
          work_q <= shift_y;
          carry  <= shift_c;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) dout <= shift_y;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == FINISH);

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request a new shift operation; sampled only in IDLE.
REQ-005 Port op, input, 2 bits: 00 SLL, 01 SRL, 10 SRA, 11 reserved (error).
REQ-006 Port amt, input, 3 bits: shift distance, 0..7.
REQ-007 Port din, input, 8 bits: operand, captured with start.
REQ-008 Port busy, output, 1 bit: high while an operation is in progress (SHIFT state).
REQ-009 Port done, output, 1 bit: single-cycle completion pulse.
REQ-010 Port dout, output, 8 bits: result register; holds its value until the next accepted start.
REQ-011 Port carry, output, 1 bit: last bit shifted out; holds like dout.
REQ-012 Port err, output, 1 bit: high with done when op=11; cleared on the next accepted start.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and FINISH.
REQ-014 IDLE with start=1 SHALL capture din into the working register, latch op, load the counter with amt, clear carry and err, and accept the start.
REQ-015 The next state after IDLE SHALL be SHIFT if amt>0 and op!=11, and FINISH otherwise.
REQ-016 In SHIFT, each cycle SHALL perform exactly one 1-bit shift of the working register, update carry, and decrement the counter.
REQ-017 SHIFT SHALL go to FINISH after the cycle in which the counter reaches 0.
REQ-018 SLL SHALL insert 0 at bit 0, and carry SHALL take bit 7.
REQ-019 SRL SHALL insert 0 at bit 7, and carry SHALL take bit 0.
REQ-020 SRA SHALL replicate bit 7, and carry SHALL take bit 0.
REQ-021 FINISH SHALL assert done for exactly one cycle, copy the working register to dout, and return to IDLE.
REQ-022 Latency SHALL be amt+1 cycles from the start-accept edge to the done cycle; amt=0 or op=11 gives 1 cycle.
REQ-023 amt=0 SHALL give dout=din and carry=0.
REQ-024 op=11 SHALL give err=1 with done, leave dout unchanged and carry=0.
REQ-025 start while busy or in FINISH SHALL be ignored, with no queuing.
REQ-026 A start asserted in the IDLE cycle immediately after FINISH SHALL be accepted, giving back-to-back operations.
REQ-027 Changes to din, op or amt after the start is accepted SHALL have no effect on the operation in flight.

Reset
REQ-028 Reset SHALL force state=IDLE, busy=0, done=0, dout=0x00, carry=0, err=0, counter=0 and working register=0, asynchronously.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset release SHALL operate normally.

Structure
REQ-030 A shared package SHALL hold the op encodings (OP_SLL, OP_SRL, OP_SRA, OP_RSVD) and the FSM state type.
REQ-031 One combinational 1-bit shifter sub-module, named shifter, SHALL perform the single-step shift.
  - Ports: A, LA, LR, Y, C.
  - SLL: LR=0.
  - SRL: LR=1, LA=0.
  - SRA: LR=1, LA=1.
REQ-032 The counter and the registers SHALL all live in shift_sequencer.

Verification
REQ-033 SLL, din=0x81, amt=1 -> done 2 cycles after accept, dout=0x02, carry=1, err=0.
REQ-034 SRA, din=0x90, amt=3 -> done 4 cycles after accept, dout=0xF2, carry=0; busy high for 3 cycles.
REQ-035 SRL, din=0x0F, amt=4 -> dout=0x00, carry=1; a second start mid-operation (din=0xFF) is ignored and dout stays 0x00.
REQ-036 amt=0, din=0xA5 -> done the next cycle, dout=0xA5, carry=0; op=11 -> done with err=1 and dout unchanged.
REQ-037 Reset asserted during SLL amt=7 -> all outputs 0 immediately, no done pulse; then SLL, din=0x01, amt=7 -> dout=0x80, carry=0.
